qarctan_arbiter: RTL and testbench

- Shares one qarctan demodulator core (with its I/R/out FIFOs) between two independent I/Q channels.
- Pops paired I/R samples from per-channel input FIFOs under round-robin arbitration and pushes them into the core's I and R FIFOs.
- Records each sample's channel in an in-order tag queue and steers each core result back to that channel's output FIFO.
- Sits between the channel front ends (read/decimate stages) and the per-channel audio paths.

---
 rtl/qarctan_arbiter.sv | 139 +++++++++++++
 tb/tb_qarctan_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qarctan_arbiter.sv
// Shares one qarctan demodulator core between two I/Q channels: round-robin issue,
// in-order tag queue steering each core result back to its originating channel.
module qarctan_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           ch0_I_empty,
    input  logic                           ch0_R_empty,
    input  logic [DATA_WIDTH-1:0]          ch0_I_dout,
    input  logic [DATA_WIDTH-1:0]          ch0_R_dout,
    output logic                           ch0_rd_en,
    input  logic                           ch1_I_empty,
    input  logic                           ch1_R_empty,
    input  logic [DATA_WIDTH-1:0]          ch1_I_dout,
    input  logic [DATA_WIDTH-1:0]          ch1_R_dout,
    output logic                           ch1_rd_en,
    input  logic                           core_I_full,
    input  logic                           core_R_full,
    output logic                           core_wr_en,
    output logic [DATA_WIDTH-1:0]          core_I_din,
    output logic [DATA_WIDTH-1:0]          core_R_din,
    input  logic                           core_out_empty,
    input  logic [DATA_WIDTH-1:0]          core_out_dout,
    output logic                           core_out_rd_en,
    input  logic                           ch0_out_full,
    input  logic                           ch1_out_full,
    output logic                           ch0_out_wr_en,
    output logic                           ch1_out_wr_en,
    output logic [DATA_WIDTH-1:0]          ch0_out_din,
    output logic [DATA_WIDTH-1:0]          ch1_out_din,
    output logic [$clog2(TAG_DEPTH):0]     inflight,
    output logic                           idle,
    output logic                           err_orphan
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TAG_DEPTH);

    logic                  rr_q, rr_d;
    logic [TAG_DEPTH-1:0]  tag_q, tag_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] ci_q, ci_d, cr_q, cr_d, o0_q, o0_d, o1_q, o1_d;

    logic elig0, elig1, grant, issue, ret, head, head_full;
    logic issue_o, ret_o;

    always_comb begin
        elig0     = enable & ~ch0_I_empty & ~ch0_R_empty;
        elig1     = enable & ~ch1_I_empty & ~ch1_R_empty;
        grant     = rr_q ? elig1 : ~elig0;
        issue     = (elig0 | elig1) & ~core_I_full & ~core_R_full & (cnt_q < DEPTH_C);
        head      = tag_q[rd_ptr_q];
        head_full = head ? ch1_out_full : ch0_out_full;
        ret       = ~core_out_empty & (cnt_q != '0) & ~head_full;

        // Outputs are masked while reset is held; the state path needs no masking
        // because every flop is held in reset anyway.
        issue_o   = issue & reset;
        ret_o     = ret & reset;

        rr_d     = rr_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ci_d     = ci_q;
        cr_d     = cr_q;
        o0_d     = o0_q;
        o1_d     = o1_q;
        err_d    = err_q | (~core_out_empty & (cnt_q == '0));

        if (issue) begin
            rr_d            = ~grant;
            tag_d[wr_ptr_q] = grant;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            ci_d            = grant ? ch1_I_dout : ch0_I_dout;
            cr_d            = grant ? ch1_R_dout : ch0_R_dout;
        end
        if (ret) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (head) o1_d = core_out_dout;
            else      o0_d = core_out_dout;
        end
        unique case ({issue, ret})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        ch0_rd_en      = issue_o & ~grant;
        ch1_rd_en      = issue_o & grant;
        core_wr_en     = issue_o;
        core_I_din     = issue_o ? ci_d : ci_q;
        core_R_din     = issue_o ? cr_d : cr_q;
        core_out_rd_en = ret_o;
        ch0_out_wr_en  = ret_o & ~head;
        ch1_out_wr_en  = ret_o & head;
        ch0_out_din    = (ret_o & ~head) ? o0_d : o0_q;
        ch1_out_din    = (ret_o & head) ? o1_d : o1_q;
        inflight       = cnt_q;
        idle           = (cnt_q == '0);
        err_orphan     = err_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q     <= 1'b0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ci_q     <= '0;
            cr_q     <= '0;
            o0_q     <= '0;
            o1_q     <= '0;
        end else begin
            rr_q     <= rr_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ci_q     <= ci_d;
            cr_q     <= cr_d;
            o0_q     <= o0_d;
            o1_q     <= o1_d;
        end
    end

endmodule

// File: tb/tb_qarctan_arbiter.sv
// Bench for qarctan_arbiter: queue-based reference model checked every cycle, a vector
// table for the credit/backpressure walk, hand sequences and a randomized soak.
module tb_qarctan_arbiter;
    localparam int DW = 32;
    localparam int TD = 4;

    logic          clock, reset, enable;
    logic          ch0_I_empty, ch0_R_empty, ch1_I_empty, ch1_R_empty;
    logic [DW-1:0] ch0_I_dout, ch0_R_dout, ch1_I_dout, ch1_R_dout;
    logic          ch0_rd_en, ch1_rd_en;
    logic          core_I_full, core_R_full, core_wr_en;
    logic [DW-1:0] core_I_din, core_R_din;
    logic          core_out_empty, core_out_rd_en;
    logic [DW-1:0] core_out_dout;
    logic          ch0_out_full, ch1_out_full, ch0_out_wr_en, ch1_out_wr_en;
    logic [DW-1:0] ch0_out_din, ch1_out_din;
    logic [$clog2(TD):0] inflight;
    logic          idle, err_orphan;

    qarctan_arbiter #(.DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .ch0_I_empty(ch0_I_empty), .ch0_R_empty(ch0_R_empty),
        .ch0_I_dout(ch0_I_dout), .ch0_R_dout(ch0_R_dout), .ch0_rd_en(ch0_rd_en),
        .ch1_I_empty(ch1_I_empty), .ch1_R_empty(ch1_R_empty),
        .ch1_I_dout(ch1_I_dout), .ch1_R_dout(ch1_R_dout), .ch1_rd_en(ch1_rd_en),
        .core_I_full(core_I_full), .core_R_full(core_R_full), .core_wr_en(core_wr_en),
        .core_I_din(core_I_din), .core_R_din(core_R_din),
        .core_out_empty(core_out_empty), .core_out_dout(core_out_dout),
        .core_out_rd_en(core_out_rd_en),
        .ch0_out_full(ch0_out_full), .ch1_out_full(ch1_out_full),
        .ch0_out_wr_en(ch0_out_wr_en), .ch1_out_wr_en(ch1_out_wr_en),
        .ch0_out_din(ch0_out_din), .ch1_out_din(ch1_out_din),
        .inflight(inflight), .idle(idle), .err_orphan(err_orphan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding channel tags in issue order, plus preferred channel.
    int            mq[$];
    bit            m_pref, m_err;
    logic [DW-1:0] m_ci, m_cr, m_o0, m_o1;
    bit            x_iss, x_g, x_ret, x_head, x_orph;
    logic [DW-1:0] x_ci, x_cr, x_o0, x_o1;

    task automatic model_reset();
        mq.delete();
        m_pref = 0; m_err = 0;
        m_ci = '0; m_cr = '0; m_o0 = '0; m_o1 = '0;
    endtask

    task automatic step_check();
        bit e0, e1, hf;
        #2;
        e0     = enable && !ch0_I_empty && !ch0_R_empty;
        e1     = enable && !ch1_I_empty && !ch1_R_empty;
        x_iss  = (e0 || e1) && !core_I_full && !core_R_full && (mq.size() < TD);
        x_g    = (m_pref == 0) ? (e0 ? 1'b0 : 1'b1) : (e1 ? 1'b1 : 1'b0);
        x_head = (mq.size() > 0) ? (mq[0] != 0) : 1'b0;
        hf     = x_head ? ch1_out_full : ch0_out_full;
        x_ret  = !core_out_empty && (mq.size() > 0) && !hf;
        x_orph = !core_out_empty && (mq.size() == 0);
        x_ci   = x_iss ? (x_g ? ch1_I_dout : ch0_I_dout) : m_ci;
        x_cr   = x_iss ? (x_g ? ch1_R_dout : ch0_R_dout) : m_cr;
        x_o0   = (x_ret && !x_head) ? core_out_dout : m_o0;
        x_o1   = (x_ret && x_head) ? core_out_dout : m_o1;
        chk("ch0_rd_en", ch0_rd_en, x_iss && !x_g);
        chk("ch1_rd_en", ch1_rd_en, x_iss && x_g);
        chk("core_wr_en", core_wr_en, x_iss);
        chk("core_I_din", core_I_din, x_ci);
        chk("core_R_din", core_R_din, x_cr);
        chk("core_out_rd_en", core_out_rd_en, x_ret);
        chk("ch0_out_wr_en", ch0_out_wr_en, x_ret && !x_head);
        chk("ch1_out_wr_en", ch1_out_wr_en, x_ret && x_head);
        chk("ch0_out_din", ch0_out_din, x_o0);
        chk("ch1_out_din", ch1_out_din, x_o1);
        chk("inflight", inflight, mq.size());
        chk("idle", idle, mq.size() == 0);
        chk("err_orphan", err_orphan, m_err);
    endtask

    task automatic step_clock();
        @(posedge clock);
        if (x_orph) m_err = 1;
        if (x_ret) void'(mq.pop_front());
        if (x_iss) begin
            mq.push_back(int'(x_g));
            m_pref = !x_g;
        end
        m_ci = x_ci; m_cr = x_cr; m_o0 = x_o0; m_o1 = x_o1;
        @(negedge clock);
    endtask

    task automatic step();
        step_check();
        step_clock();
    endtask

    task automatic drive(input bit en, input bit a0, input bit a1, input bit cf,
                         input bit oe, input bit f0, input bit f1);
        enable = en;
        ch0_I_empty = !a0; ch0_R_empty = !a0;
        ch1_I_empty = !a1; ch1_R_empty = !a1;
        core_I_full = cf;  core_R_full = cf;
        core_out_empty = oe;
        ch0_out_full = f0; ch1_out_full = f1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        bit en, a0, a1, cf, oe, f0, f1;
        bit rd0, rd1, ret, o0, o1;
        int inf;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n0, n1, nb0, nb1, ret_seq[$];

        // en a0 a1 cf oe f0 f1 | rd0 rd1 ret o0 o1 | inflight   (TAG_DEPTH = 4)
        tbl[0]  = '{1,1,1,0,1,0,0, 1,0,0,0,0, 0};
        tbl[1]  = '{1,1,1,0,1,0,0, 0,1,0,0,0, 1};
        tbl[2]  = '{1,0,1,0,1,0,0, 0,1,0,0,0, 2};
        tbl[3]  = '{1,1,1,0,0,0,0, 1,0,1,1,0, 3};
        tbl[4]  = '{1,1,1,0,0,0,1, 0,1,0,0,0, 3};
        tbl[5]  = '{1,1,1,0,1,0,0, 0,0,0,0,0, 4};
        tbl[6]  = '{0,1,1,0,0,0,0, 0,0,1,0,1, 4};
        tbl[7]  = '{0,1,1,1,0,0,0, 0,0,1,0,1, 3};
        tbl[8]  = '{1,1,1,1,0,1,0, 0,0,0,0,0, 2};
        tbl[9]  = '{1,1,0,0,0,0,0, 1,0,1,1,0, 2};
        tbl[10] = '{0,0,0,0,0,0,0, 0,0,1,0,1, 2};
        tbl[11] = '{0,0,0,0,0,0,0, 0,0,1,1,0, 1};
        tbl[12] = '{0,0,0,0,1,0,0, 0,0,0,0,0, 0};

        reset = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 0);
        ch0_I_dout = 100; ch0_R_dout = 200; ch1_I_dout = 300; ch1_R_dout = 400;
        core_out_dout = '0;
        model_reset();
        @(negedge clock);
        #1;
        chk("reset_idle", idle, 1);
        chk("reset_inflight", inflight, 0);
        chk("reset_core_I_din", core_I_din, 0);
        @(negedge clock);
        reset = 1'b1;

        // Vector table: credit limit, head-of-line stall, enable drain
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].en, tbl[i].a0, tbl[i].a1, tbl[i].cf, tbl[i].oe, tbl[i].f0, tbl[i].f1);
            core_out_dout = 1000 + i;
            step_check();
            chk($sformatf("tbl%0d_rd0", i), ch0_rd_en, tbl[i].rd0);
            chk($sformatf("tbl%0d_rd1", i), ch1_rd_en, tbl[i].rd1);
            chk($sformatf("tbl%0d_wr", i), core_wr_en, tbl[i].rd0 | tbl[i].rd1);
            chk($sformatf("tbl%0d_ret", i), core_out_rd_en, tbl[i].ret);
            chk($sformatf("tbl%0d_o0", i), ch0_out_wr_en, tbl[i].o0);
            chk($sformatf("tbl%0d_o1", i), ch1_out_wr_en, tbl[i].o1);
            chk($sformatf("tbl%0d_inflight", i), inflight, tbl[i].inf);
            step_clock();
        end

        // Single channel: four ch0 samples, all results land on ch0 in order
        do_reset();
        nb0 = 0; nb1 = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 1, 0, 0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            core_out_dout = 50 + i;
            step_check();
            if (ch0_out_wr_en) begin
                nb0++;
                chk("single_order", ch0_out_din, 50 + i);
            end
            if (ch1_out_wr_en) nb1++;
            step_clock();
        end
        chk("single_ch0_count", nb0, 4);
        chk("single_ch1_count", nb1, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        chk("single_idle", idle, 1);

        // Fairness with steady-state issue+return, tag pointers wrap repeatedly
        do_reset();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, 0, mq.size() == 0, 0, 0);
            core_out_dout = 2000 + i;
            step_check();
            chk($sformatf("fair_grant%0d", i), ch1_rd_en, i % 2);
            if (i > 0) chk($sformatf("steady_inflight%0d", i), inflight, 1);
            if (ch0_rd_en) n0++;
            if (ch1_rd_en) n1++;
            step_clock();
        end
        chk("fair_n0", n0, 10);
        chk("fair_n1", n1, 10);

        // Backpressure: head is ch1, ch1 output full for 6 cycles, ch0 results queued behind
        do_reset();
        drive(1, 0, 1, 0, 1, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 1, 0, 0);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            step_check();
            chk($sformatf("hol_stall%0d", i), core_out_rd_en, 0);
            step_clock();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            core_out_dout = 3000 + i;
            step_check();
            if (ch1_out_wr_en) ret_seq.push_back(1);
            if (ch0_out_wr_en) ret_seq.push_back(0);
            step_clock();
        end
        chk("hol_count", ret_seq.size(), 4);
        if (ret_seq.size() == 4) begin
            chk("hol_order0", ret_seq[0], 1);
            chk("hol_order1", ret_seq[1], 0);
            chk("hol_order3", ret_seq[3], 0);
        end

        // Orphan: result with nothing outstanding is flagged and left in place
        drive(0, 0, 0, 0, 0, 0, 0);
        step_check();
        chk("orphan_no_pop", core_out_rd_en, 0);
        step_clock();
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        chk("orphan_sticky", err_orphan, 1);

        // Randomized soak with a mid-cycle reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 400; i++) begin
            enable         = $urandom_range(0, 9) != 0;
            ch0_I_empty    = $urandom_range(0, 3) == 0;
            ch0_R_empty    = $urandom_range(0, 4) == 0;
            ch1_I_empty    = $urandom_range(0, 3) == 0;
            ch1_R_empty    = $urandom_range(0, 4) == 0;
            core_I_full    = $urandom_range(0, 5) == 0;
            core_R_full    = $urandom_range(0, 5) == 0;
            core_out_empty = (mq.size() == 0) ? ($urandom_range(0, 29) != 0)
                                              : ($urandom_range(0, 2) == 0);
            ch0_out_full   = $urandom_range(0, 3) == 0;
            ch1_out_full   = $urandom_range(0, 3) == 0;
            ch0_I_dout = $urandom; ch0_R_dout = $urandom;
            ch1_I_dout = $urandom; ch1_R_dout = $urandom;
            core_out_dout = $urandom;
            step();
            if (i == 200) begin
                drive(1, 1, 1, 0, 0, 0, 0);
                #3;
                reset = 1'b0;
                #1;
                chk("rst_core_wr_en", core_wr_en, 0);
                chk("rst_rd_en", ch0_rd_en | ch1_rd_en, 0);
                chk("rst_out_rd_en", core_out_rd_en, 0);
                chk("rst_out_wr_en", ch0_out_wr_en | ch1_out_wr_en, 0);
                chk("rst_data", core_I_din | core_R_din | ch0_out_din | ch1_out_din, 0);
                chk("rst_inflight", inflight, 0);
                chk("rst_err", err_orphan, 0);
                model_reset();
                @(posedge clock);
                @(negedge clock);
                reset = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
